// File: rtl/riscv_pkg.sv
// Shared core definitions: opcodes, branch conditions, ALU and mul/div encodings,
// and the execute-stage mul/div FSM states.
package riscv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_OP     = 7'h33;

    localparam logic [2:0] BR_EQ  = 3'd0;
    localparam logic [2:0] BR_NE  = 3'd1;
    localparam logic [2:0] BR_LT  = 3'd4;
    localparam logic [2:0] BR_GE  = 3'd5;
    localparam logic [2:0] BR_LTU = 3'd6;
    localparam logic [2:0] BR_GEU = 3'd7;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Divide and remainder ops all have funct3[2] set.
    function automatic logic md_is_div(md_op_e op);
        return op[2];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic md_a_signed(md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM.
    function automatic logic md_b_signed(md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// ID/EX -> EX/MEM bundle for the execute stage.
// Handshake: an instruction is taken on a rising clk edge where in_valid && in_ready
// and flush is low; the producer holds its fields stable while in_valid is high and
// in_ready is low. out_valid marks a result; while out_valid && out_stall every out_*
// and redirect field stays frozen until the consumer drops out_stall.
interface execute_pipe_if #(parameter int XLEN = 32);
    import riscv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_muldiv;
    logic            alusrc;
    logic [3:0]      aluctrl;
    logic            addupper;
    logic            jbmux;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            flush;
    logic            out_stall;
    logic            out_valid;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_rs2;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    md_state_e       fsm_state;

    modport master (
        output in_valid, opcode, funct3, is_muldiv, alusrc, aluctrl, addupper, jbmux,
               rs1, rs2, imm, pc, rd, flush, out_stall,
        input  in_ready, out_valid, out_result, out_rd, out_rs2, redirect, redirect_pc,
               fsm_state
    );

    modport slave (
        input  in_valid, opcode, funct3, is_muldiv, alusrc, aluctrl, addupper, jbmux,
               rs1, rs2, imm, pc, rd, flush, out_stall,
        output in_ready, out_valid, out_result, out_rd, out_rs2, redirect, redirect_pc,
               fsm_state
    );

endinterface

// File: rtl/alu.sv
// Shared integer ALU used by the execute stage.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] y
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] shamt;
    assign shamt = b[SW-1:0];

    // Pure combinational operation select.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << shamt;
            ALU_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = $signed(a) >>> shamt;
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide: one shift-add or restoring-divide step per cycle on
// operand magnitudes, with sign fix-up applied combinationally to the final value.
module muldiv_iter
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            start,
    input  md_op_e          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;        // mul: {high, low/multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   mag_op;     // multiplicand or divisor magnitude
    md_op_e            op_q;
    logic              neg_q;      // product or quotient must be negated
    logic              neg_r;      // remainder must be negated
    logic              div0;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] acc_next;

    assign a_neg = md_a_signed(op) & a[XLEN-1];
    assign b_neg = md_b_signed(op) & b[XLEN-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // The step completing this cycle is the last one.
    assign done = busy && (count == '0);

    // One iteration of the active algorithm.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_op} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_op};
        acc_next  = {mul_sum, acc[XLEN-1:1]};
        if (md_is_div(op_q)) begin
            if (!div_diff[XLEN]) acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else                 acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    // Operand latch on start, then one step per cycle until the count runs out.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mag_op <= '0;
            op_q   <= MD_MUL;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else if (kill) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CW'(XLEN - 1);
            op_q  <= op;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            div0  <= (b == '0);
            if (md_is_div(op)) begin
                acc    <= {{XLEN{1'b0}}, mag_a};
                mag_op <= mag_b;
            end else begin
                acc    <= {{XLEN{1'b0}}, mag_b};
                mag_op <= mag_a;
            end
        end else if (busy) begin
            acc <= acc_next;
            if (count == '0) busy <= 1'b0;
            else             count <= count - 1'b1;
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    assign prod = neg_q ? -acc : acc;
    assign quo  = acc[XLEN-1:0];
    assign rem  = acc[2*XLEN-1:XLEN];

    // Final result select with sign and divide-by-zero handling.
    always_comb begin
        result = '0;
        case (op_q)
            MD_MUL:    result = prod[XLEN-1:0];
            MD_MULH,
            MD_MULHSU,
            MD_MULHU:  result = prod[2*XLEN-1:XLEN];
            MD_DIV:    result = div0 ? '1 : (neg_q ? -quo : quo);
            MD_DIVU:   result = div0 ? '1 : quo;
            MD_REM:    result = neg_r ? -rem : rem;
            MD_REMU:   result = rem;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute_pipe.sv
// Pipelined execute stage: ALU, branch resolution, PC redirect and a registered
// EX/MEM result; M-extension ops go to the iterative mul/div unit.
module execute_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit MD_ENABLE = 1'b1
) (
    input logic           clk,
    input logic           rst,
    execute_pipe_if.slave bus
);

    md_state_e       state, state_next;
    logic            hold, accept, md_start, sc_accept;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    logic [XLEN-1:0] target, pc_plus4, sc_result;
    logic            br_cond, is_branch, is_jump, take;
    logic            md_busy, md_done;
    logic [XLEN-1:0] md_result;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_rs2;
    md_op_e          md_op;

    assign hold         = bus.out_valid && bus.out_stall;
    assign bus.in_ready = (state == IDLE) && !md_busy && !hold;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
    assign md_start     = accept && bus.is_muldiv && MD_ENABLE;
    assign sc_accept    = accept && !md_start;
    assign md_op        = md_op_e'(bus.funct3);
    assign bus.fsm_state = state;

    assign alu_a = bus.addupper ? bus.pc : bus.rs1;
    assign alu_b = bus.alusrc ? bus.imm : bus.rs2;

    alu #(.XLEN(XLEN)) u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op_e'(bus.aluctrl)),
        .y  (alu_y)
    );

    // Branch condition from the raw register operands.
    always_comb begin
        br_cond = 1'b0;
        case (bus.funct3)
            BR_EQ:   br_cond = (bus.rs1 == bus.rs2);
            BR_NE:   br_cond = (bus.rs1 != bus.rs2);
            BR_LT:   br_cond = ($signed(bus.rs1) <  $signed(bus.rs2));
            BR_GE:   br_cond = ($signed(bus.rs1) >= $signed(bus.rs2));
            BR_LTU:  br_cond = (bus.rs1 <  bus.rs2);
            BR_GEU:  br_cond = (bus.rs1 >= bus.rs2);
            default: br_cond = 1'b0;
        endcase
    end

    assign is_branch = (bus.opcode == OP_BRANCH);
    assign is_jump   = (bus.opcode == OP_JAL) || (bus.opcode == OP_JALR);
    assign take      = is_jump || (is_branch && br_cond);
    assign target    = bus.jbmux ? (alu_y & ~XLEN'(1)) : (bus.pc + bus.imm);
    assign pc_plus4  = bus.pc + XLEN'(4);
    // With the mul/div unit absent, M-extension ops retire here with a zero result.
    assign sc_result = is_jump ? pc_plus4 : (bus.is_muldiv ? '0 : alu_y);

    generate
        if (MD_ENABLE) begin : g_md
            muldiv_iter #(.XLEN(XLEN)) u_md (
                .clk    (clk),
                .rst    (rst),
                .kill   (bus.flush),
                .start  (md_start),
                .op     (md_op),
                .a      (bus.rs1),
                .b      (bus.rs2),
                .busy   (md_busy),
                .done   (md_done),
                .result (md_result)
            );
        end else begin : g_no_md
            assign md_busy   = 1'b0;
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

    // Mul/div FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Mul/div FSM next state; flush always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (md_start) state_next = BUSY;
            BUSY:    if (md_done)  state_next = DONE;
            DONE:    if (!hold)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    // Destination and store data of the mul/div op, held until it retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_rd  <= '0;
            md_rs2 <= '0;
        end else if (md_start) begin
            md_rd  <= bus.rd;
            md_rs2 <= bus.rs2;
        end
    end

    // EX/MEM result register: flush wins, then stall hold, then new results.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_result  <= '0;
            bus.out_rd      <= '0;
            bus.out_rs2     <= '0;
            bus.redirect    <= 1'b0;
            bus.redirect_pc <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            bus.redirect  <= 1'b0;
        end else if (hold) begin
            bus.out_valid <= 1'b1;
        end else if (sc_accept) begin
            bus.out_valid   <= 1'b1;
            bus.out_result  <= sc_result;
            bus.out_rd      <= bus.rd;
            bus.out_rs2     <= bus.rs2;
            bus.redirect    <= take;
            bus.redirect_pc <= target;
        end else if (state == DONE) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= md_result;
            bus.out_rd     <= md_rd;
            bus.out_rs2    <= md_rs2;
            bus.redirect   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.redirect  <= 1'b0;
        end
    end

endmodule
